// File: rtl/logo_scroll_ctrl.sv
// Bounces the logo offset `delt` between 0 and DELT_MAX, dwelling at each end.
// Every register moves only on a frame tick while enabled, so a frame never sees two offsets.
module logo_scroll_ctrl #(
  parameter int FRAMES_PER_STEP = 2,
  parameter int STEP            = 1,
  parameter int DELT_MAX        = 200,
  parameter int HOLD_FRAMES     = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        enable,
  output logic [10:0] delt,
  output logic        dir_left,
  output logic        at_edge,
  output logic [1:0]  state_dbg
);

  localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int HCW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAMES_PER_STEP - 1);
  localparam logic [HCW-1:0] HC_LAST  = HCW'(HOLD_FRAMES - 1);
  localparam logic [11:0]    STEP_W   = 12'(STEP);
  localparam logic [11:0]    MAX_W    = 12'(DELT_MAX);

  typedef enum logic [1:0] {
    MOVE_R = 2'd0,
    HOLD_R = 2'd1,
    MOVE_L = 2'd2,
    HOLD_L = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [FCW-1:0]  frame_cnt, frame_cnt_nx;
  logic [HCW-1:0]  hold_cnt, hold_cnt_nx;
  logic [10:0]     delt_nx;
  logic            dir_left_nx, at_edge_nx;

  logic            qual, step_tick;
  logic [11:0]     delt_w, sum_w;

  assign qual      = frame_tick & enable;
  assign step_tick = qual && (frame_cnt == FC_LAST);
  // 12-bit arithmetic so delt+STEP cannot wrap before the clamp compare.
  assign delt_w    = {1'b0, delt};
  assign sum_w     = delt_w + STEP_W;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= MOVE_R;
      frame_cnt <= '0;
      hold_cnt  <= '0;
      delt      <= '0;
      dir_left  <= 1'b0;
      at_edge   <= 1'b0;
    end else begin
      state     <= state_nx;
      frame_cnt <= frame_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      delt      <= delt_nx;
      dir_left  <= dir_left_nx;
      at_edge   <= at_edge_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    frame_cnt_nx = frame_cnt;
    hold_cnt_nx  = hold_cnt;
    delt_nx      = delt;
    dir_left_nx  = dir_left;
    at_edge_nx   = at_edge;

    if (qual) begin
      unique case (state)
        MOVE_R: begin
          frame_cnt_nx = step_tick ? '0 : frame_cnt + 1'b1;
          if (step_tick) begin
            if (sum_w >= MAX_W) begin
              delt_nx     = MAX_W[10:0];
              state_nx    = HOLD_R;
              at_edge_nx  = 1'b1;
              hold_cnt_nx = '0;
            end else begin
              delt_nx = sum_w[10:0];
            end
          end
        end
        HOLD_R: begin
          hold_cnt_nx = hold_cnt + 1'b1;
          if (hold_cnt == HC_LAST) begin
            state_nx     = MOVE_L;
            dir_left_nx  = 1'b1;
            at_edge_nx   = 1'b0;
            frame_cnt_nx = '0;
          end
        end
        MOVE_L: begin
          frame_cnt_nx = step_tick ? '0 : frame_cnt + 1'b1;
          if (step_tick) begin
            // Clamping at STEP keeps delt from ever going below zero.
            if (delt_w <= STEP_W) begin
              delt_nx     = '0;
              state_nx    = HOLD_L;
              at_edge_nx  = 1'b1;
              hold_cnt_nx = '0;
            end else begin
              delt_nx = delt - STEP_W[10:0];
            end
          end
        end
        HOLD_L: begin
          hold_cnt_nx = hold_cnt + 1'b1;
          if (hold_cnt == HC_LAST) begin
            state_nx     = MOVE_R;
            dir_left_nx  = 1'b0;
            at_edge_nx   = 1'b0;
            frame_cnt_nx = '0;
          end
        end
        default: state_nx = MOVE_R;
      endcase
    end
  end

endmodule

// File: tb/tb_logo_scroll_ctrl.sv
// Directed bench for logo_scroll_ctrl with FRAMES_PER_STEP=2, STEP=3, DELT_MAX=10, HOLD_FRAMES=2.
module tb_logo_scroll_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        enable;
  logic [10:0] delt;
  logic        dir_left;
  logic        at_edge;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic [10:0] d;
    logic        dl;
    logic        ae;
  } vec_t;

  vec_t vq[$];
  logic [10:0] prev_d;
  logic        prev_dl, prev_ae;

  logo_scroll_ctrl #(
    .FRAMES_PER_STEP(2),
    .STEP(3),
    .DELT_MAX(10),
    .HOLD_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_tick(frame_tick),
    .enable(enable),
    .delt(delt),
    .dir_left(dir_left),
    .at_edge(at_edge),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_out(input string name, input logic [10:0] d,
                           input logic dl, input logic ae);
    checks++;
    if (delt !== d || dir_left !== dl || at_edge !== ae) begin
      failures++;
      $display("FAIL %s: got delt=%0d dir_left=%b at_edge=%b, expected delt=%0d dir_left=%b at_edge=%b",
               name, delt, dir_left, at_edge, d, dl, ae);
    end
  endtask

  task automatic add(input logic en, input int d, input logic dl, input logic ae);
    vec_t v;
    v.en = en; v.d = 11'(d); v.dl = dl; v.ae = ae;
    vq.push_back(v);
  endtask

  // One-cycle tick; outputs must not move before the edge, and must show the new value after it.
  task automatic tick(input string name, input logic en, input logic [10:0] d,
                      input logic dl, input logic ae);
    @(negedge clk);
    frame_tick = 1'b1;
    enable     = en;
    check_out({name, "_pre"}, prev_d, prev_dl, prev_ae);
    @(negedge clk);
    frame_tick = 1'b0;
    check_out(name, d, dl, ae);
    prev_d = d; prev_dl = dl; prev_ae = ae;
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; enable = 1'b1;
    prev_d = '0; prev_dl = 1'b0; prev_ae = 1'b0;

    // Full bounce, then a freeze with a partially counted frame (frame_cnt=1, delt=6).
    add(1, 0, 0, 0);  add(1, 3, 0, 0);  add(1, 3, 0, 0);  add(1, 6, 0, 0);
    add(1, 6, 0, 0);  add(1, 9, 0, 0);  add(1, 9, 0, 0);  add(1, 10, 0, 1);
    add(1, 10, 0, 1); add(1, 10, 1, 0); add(1, 10, 1, 0); add(1, 7, 1, 0);
    add(1, 7, 1, 0);  add(1, 4, 1, 0);  add(1, 4, 1, 0);  add(1, 1, 1, 0);
    add(1, 1, 1, 0);  add(1, 0, 1, 1);  add(1, 0, 1, 1);  add(1, 0, 0, 0);
    add(1, 0, 0, 0);  add(1, 3, 0, 0);  add(1, 3, 0, 0);  add(1, 6, 0, 0);
    add(1, 6, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 6, 0, 0);
    add(1, 9, 0, 0);

    repeat (3) @(negedge clk);
    check_out("reset_state", 11'd0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      tick($sformatf("vec%0d", i), vq[i].en, vq[i].d, vq[i].dl, vq[i].ae);

    // Long idle with no ticks: nothing may change.
    repeat (1000) @(negedge clk);
    check_out("idle_1000", 11'd9, 1'b0, 1'b0);

    // Reach the right edge, then reset asynchronously in the middle of a clock low phase.
    tick("pre_rst_a", 1'b1, 11'd9, 1'b0, 1'b0);
    tick("pre_rst_b", 1'b1, 11'd10, 1'b0, 1'b1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_out("async_reset", 11'd0, 1'b0, 1'b0);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check_out("tick_in_reset", 11'd0, 1'b0, 1'b0);
    rst = 1'b1;
    prev_d = '0; prev_dl = 1'b0; prev_ae = 1'b0;

    // frame_cnt must restart from 0 after reset.
    tick("post_rst_a", 1'b1, 11'd0, 1'b0, 1'b0);
    tick("post_rst_b", 1'b1, 11'd3, 1'b0, 1'b0);

    // A two-cycle-wide tick counts as two ticks.
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (2) @(negedge clk);
    frame_tick = 1'b0;
    check_out("wide_tick", 11'd6, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
